// File: rtl/lift_pkg.sv
// Shared constants for the lift status display: controller state codes,
// active-low seven-segment glyphs and the door animation state encoding.
package lift_pkg;

    localparam logic [2:0] ST_PODRUM    = 3'b000;
    localparam logic [2:0] ST_UP01      = 3'b001;
    localparam logic [2:0] ST_PRIZEMLJE = 3'b010;
    localparam logic [2:0] ST_UP12      = 3'b011;
    localparam logic [2:0] ST_SPRAT     = 3'b100;
    localparam logic [2:0] ST_DN21      = 3'b101;
    localparam logic [2:0] ST_DN10      = 3'b110;

    // bit0 = a ... bit6 = g, a segment is lit when its bit is 0
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_UP    = 7'b1111110;
    localparam logic [6:0] SEG_DOWN  = 7'b1110111;
    localparam logic [6:0] SEG_BAR_R = 7'b1111001;
    localparam logic [6:0] SEG_BAR_L = 7'b1001111;

    typedef enum logic [1:0] {
        DOOR_CLOSED  = 2'd0,
        DOOR_OPENING = 2'd1,
        DOOR_OPEN    = 2'd2,
        DOOR_CLOSING = 2'd3
    } door_state_t;

endpackage

// File: rtl/lift_tick_gen.sv
// Timebase for the display: base tick prescaler, direction-arrow blink phase
// and the free-running door animation step.
module lift_tick_gen #(
    parameter int TICK_DIV    = 5_000_000,
    parameter int BLINK_TICKS = 3,
    parameter int DOOR_TICKS  = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic step,
    output logic phase
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;
    logic [DW-1:0] door_cnt;

    // With TICK_DIV=1 the prescaler sits at 0 and tick is high every clk
    assign tick = (presc == PW'(TICK_DIV - 1));
    assign step = tick && (door_cnt == DW'(DOOR_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            blink_cnt <= '0;
            door_cnt  <= '0;
            phase     <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
                if (step) begin
                    door_cnt <= '0;
                end else begin
                    door_cnt <= door_cnt + DW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/lift_display.sv
// Lift status display: floor digits, blinking direction arrow, door
// open/close animation and request lamps, all driven from registers.
module lift_display
    import lift_pkg::*;
#(
    parameter int TICK_DIV    = 5_000_000,
    parameter int BLINK_TICKS = 3,
    parameter int DOOR_TICKS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] tstanje,
    input  logic [4:0] sticiDo,
    input  logic       vrata,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    logic        tick;
    logic        step;
    logic        phase;
    door_state_t door_state;
    door_state_t door_next;
    logic [6:0]  floor_seg;
    logic [6:0]  sign_seg;
    logic [6:0]  dir_seg;
    logic [6:0]  door_left_seg;
    logic [6:0]  door_right_seg;
    logic        moving;

    lift_tick_gen #(
        .TICK_DIV    (TICK_DIV),
        .BLINK_TICKS (BLINK_TICKS),
        .DOOR_TICKS  (DOOR_TICKS)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .step  (step),
        .phase (phase)
    );

    always_comb begin
        door_next = door_state;
        if (tick && step) begin
            case (door_state)
                DOOR_CLOSED:  if (vrata) door_next = DOOR_OPENING;
                DOOR_OPENING: door_next = vrata ? DOOR_OPEN : DOOR_CLOSING;
                DOOR_OPEN:    if (!vrata) door_next = DOOR_CLOSING;
                DOOR_CLOSING: door_next = vrata ? DOOR_OPENING : DOOR_CLOSED;
                default:      door_next = DOOR_CLOSED;
            endcase
        end
    end

    // Travelling states keep showing the floor the car just left
    always_comb begin
        sign_seg  = SEG_BLANK;
        floor_seg = SEG_E;
        case (tstanje)
            ST_PODRUM, ST_UP01: begin
                sign_seg  = SEG_MINUS;
                floor_seg = SEG_ONE;
            end
            ST_PRIZEMLJE, ST_UP12, ST_DN10: floor_seg = SEG_ZERO;
            ST_SPRAT, ST_DN21:              floor_seg = SEG_ONE;
            default:                        floor_seg = SEG_E;
        endcase
    end

    always_comb begin
        dir_seg = SEG_BLANK;
        moving  = 1'b0;
        case (tstanje)
            ST_UP01, ST_UP12: begin
                moving = 1'b1;
                if (phase) dir_seg = SEG_UP;
            end
            ST_DN21, ST_DN10: begin
                moving = 1'b1;
                if (phase) dir_seg = SEG_DOWN;
            end
            default: dir_seg = SEG_BLANK;
        endcase
    end

    // Door digits follow the state being entered so they change with it
    always_comb begin
        door_left_seg  = SEG_BAR_L;
        door_right_seg = SEG_BAR_R;
        case (door_next)
            DOOR_CLOSED: begin
                door_left_seg  = SEG_BAR_R;
                door_right_seg = SEG_BAR_L;
            end
            DOOR_OPEN: begin
                door_left_seg  = SEG_BLANK;
                door_right_seg = SEG_BLANK;
            end
            default: begin
                door_left_seg  = SEG_BAR_L;
                door_right_seg = SEG_BAR_R;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            door_state <= DOOR_CLOSED;
        end else begin
            door_state <= door_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            HEX0 <= SEG_BLANK;
            HEX1 <= SEG_BLANK;
            HEX2 <= SEG_BLANK;
            HEX3 <= SEG_BLANK;
            HEX4 <= SEG_BAR_L;
            HEX5 <= SEG_BAR_R;
            LEDR <= '0;
        end else begin
            HEX0 <= floor_seg;
            HEX1 <= sign_seg;
            HEX2 <= dir_seg;
            HEX3 <= SEG_BLANK;
            HEX4 <= door_right_seg;
            HEX5 <= door_left_seg;
            LEDR <= {(door_next == DOOR_OPEN), moving, 3'b000, sticiDo};
        end
    end

endmodule

// File: tb/tb_lift_display.sv
// Self-checking bench for lift_display: directed scenarios with literal
// expectations plus randomized traffic against a time-based reference model.
module tb_lift_display;

    localparam int TD = 4;
    localparam int BT = 2;
    localparam int DT = 3;

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] ZERO  = 7'b1000000;
    localparam logic [6:0] ONE   = 7'b1111001;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] EGLY  = 7'b0000110;
    localparam logic [6:0] UP    = 7'b1111110;
    localparam logic [6:0] DOWN  = 7'b1110111;
    localparam logic [6:0] BAR_R = 7'b1111001;
    localparam logic [6:0] BAR_L = 7'b1001111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_en = 1'b0;
    logic       cmp_en = 1'b0;
    logic [2:0] tstanje = 3'b000;
    logic [4:0] sticiDo = 5'b00000;
    logic       vrata = 1'b0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int errors = 0;
    int checks = 0;

    lift_display #(
        .TICK_DIV    (TD),
        .BLINK_TICKS (BT),
        .DOOR_TICKS  (DT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tstanje (tstanje),
        .sticiDo (sticiDo),
        .vrata   (vrata),
        .HEX0    (HEX0),
        .HEX1    (HEX1),
        .HEX2    (HEX2),
        .HEX3    (HEX3),
        .HEX4    (HEX4),
        .HEX5    (HEX5),
        .LEDR    (LEDR)
    );

    initial begin
        wait (clk_en);
        forever #10 clk = ~clk;
    end

    task automatic check7(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check10(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: n = clock edges since reset release; the door moves
    // every TD*DT edges, the arrow phase flips every TD*BT edges.
    int         n = 0;
    int         m_door = 0;  // 0 closed, 1 opening, 2 open, 3 closing
    logic [6:0] e0, e1, e2, e4, e5;
    logic [9:0] e_ledr;

    always @(posedge clk or posedge rst) begin
        int  fl;
        int  ph;
        bit  up;
        bit  dn;
        if (rst) begin
            n = 0;
            m_door = 0;
            e0 = BLANK; e1 = BLANK; e2 = BLANK;
            e5 = BAR_R; e4 = BAR_L;
            e_ledr = '0;
        end else begin
            n++;
            if (n % (TD * DT) == 0) begin
                case (m_door)
                    0: m_door = vrata ? 1 : 0;
                    1: m_door = vrata ? 2 : 3;
                    2: m_door = vrata ? 2 : 3;
                    default: m_door = vrata ? 1 : 0;
                endcase
            end
            case (tstanje)
                3'd0, 3'd1:       fl = -1;
                3'd2, 3'd3, 3'd6: fl = 0;
                3'd4, 3'd5:       fl = 1;
                default:          fl = 2;
            endcase
            e1 = (fl == -1) ? MINUS : BLANK;
            e0 = (fl == 2) ? EGLY : ((fl == 0) ? ZERO : ONE);
            up = (tstanje == 3'd1) || (tstanje == 3'd3);
            dn = (tstanje == 3'd5) || (tstanje == 3'd6);
            ph = ((n - 1) / (TD * BT)) % 2;
            e2 = (up && ph == 1) ? UP : ((dn && ph == 1) ? DOWN : BLANK);
            case (m_door)
                0:       begin e5 = BAR_R; e4 = BAR_L; end
                2:       begin e5 = BLANK; e4 = BLANK; end
                default: begin e5 = BAR_L; e4 = BAR_R; end
            endcase
            e_ledr = {(m_door == 2), (up || dn), 3'b000, sticiDo};
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check7("hex0", HEX0, e0);
            check7("hex1", HEX1, e1);
            check7("hex2", HEX2, e2);
            check7("hex3", HEX3, BLANK);
            check7("hex4", HEX4, e4);
            check7("hex5", HEX5, e5);
            check10("ledr", LEDR, e_ledr);
        end
    end

    initial begin
        int  cnt;
        int  ups;
        int  other;
        int  bad;
        bit  found;

        #1 rst = 1'b1;
        #4;
        check7("rst_hex0", HEX0, 7'h7F);
        check7("rst_hex1", HEX1, 7'h7F);
        check7("rst_hex2", HEX2, 7'h7F);
        check7("rst_hex3", HEX3, 7'h7F);
        check7("rst_hex4", HEX4, 7'b1001111);
        check7("rst_hex5", HEX5, 7'b1111001);
        check10("rst_ledr", LEDR, 10'd0);

        clk_en = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        tstanje = 3'b000;
        @(negedge clk);
        check7("floor000_hex1", HEX1, 7'b0111111);
        check7("floor000_hex0", HEX0, 7'b1111001);
        tstanje = 3'b100;
        @(negedge clk);
        check7("floor100_hex1", HEX1, 7'h7F);
        check7("floor100_hex0", HEX0, 7'b1111001);
        tstanje = 3'b111;
        @(negedge clk);
        check7("floor111_hex0", HEX0, 7'b0000110);

        tstanje = 3'b001;
        @(negedge clk);
        check10("moving_led8", {9'd0, LEDR[8]}, 10'd1);
        ups = 0;
        other = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (HEX2 == 7'b1111110) ups++;
            else if (HEX2 != 7'h7F) other++;
        end
        checki("blink_up_count", ups, 8);
        checki("blink_other", other, 0);
        tstanje = 3'b110;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (HEX2 == 7'b1110111) found = 1;
        end
        checki("down_arrow_seen", int'(found), 1);

        tstanje = 3'b010;
        vrata = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (HEX5 == 7'b1001111) found = 1;
        end
        checki("door_opening_seen", int'(found), 1);
        found = 0;
        cnt = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            cnt++;
            if (HEX5 == 7'h7F) found = 1;
        end
        checki("door_step_interval", cnt, 12);
        check10("door_open_led9", {9'd0, LEDR[9]}, 10'd1);
        check7("door_open_hex4", HEX4, 7'h7F);
        vrata = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (HEX5 == 7'b1111001 && LEDR[9] == 1'b0) found = 1;
        end
        checki("door_closed_again", int'(found), 1);

        vrata = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (HEX5 == 7'b1001111) found = 1;
        end
        checki("reversal_opening_seen", int'(found), 1);
        vrata = 1'b0;
        bad = 0;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            if (HEX5 != 7'b1001111 || HEX4 != 7'b1111001 || LEDR[9] != 1'b0) bad++;
        end
        checki("reversal_bars_held", bad, 0);
        @(negedge clk);
        check7("reversal_closed_hex5", HEX5, 7'b1111001);
        check7("reversal_closed_hex4", HEX4, 7'b1001111);

        sticiDo = 5'b10101;
        tstanje = 3'b010;
        @(negedge clk);
        check10("request_lamps", LEDR, 10'b0000010101);

        vrata = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (LEDR[9]) found = 1;
        end
        checki("open_before_reset", int'(found), 1);
        #3 rst = 1'b1;
        #1;
        check7("async_rst_hex5", HEX5, 7'b1111001);
        check7("async_rst_hex4", HEX4, 7'b1001111);
        check10("async_rst_ledr", LEDR, 10'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst = 1'b0;
            if ($urandom_range(5, 0) == 0) tstanje = 3'($urandom_range(7, 0));
            if ($urandom_range(3, 0) == 0) sticiDo = 5'($urandom_range(31, 0));
            if ($urandom_range(9, 0) == 0) vrata = ~vrata;
            if ($urandom_range(299, 0) == 0) begin
                #3 rst = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
